// File: rtl/xnor_pkg.sv
// Shared definitions for the XNOR-net vector datapath: scheduler state
// encoding, default widths and the lane-slice helper.
package xnor_pkg;

  localparam int DEF_TOTAL_WIDTH = 32;
  localparam int DEF_VECTOR_SIZE = 8;
  localparam int DEF_CNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bit offset of lane 'lane' in a packed vector of 'width'-bit elements.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/scalar_multiplier_v.sv
// Combinational per-lane scalar multiply; each product wraps to the low
// TOTAL_WIDTH bits of the full signed product.
module scalar_multiplier_v
  import xnor_pkg::*;
#(
  parameter int TOTAL_WIDTH = DEF_TOTAL_WIDTH,
  parameter int VECTOR_SIZE = DEF_VECTOR_SIZE
) (
  input  logic [TOTAL_WIDTH-1:0]             scalar_i,
  input  logic [TOTAL_WIDTH*VECTOR_SIZE-1:0] vec_i,
  output logic [TOTAL_WIDTH*VECTOR_SIZE-1:0] prod_o
);

  // The low half of a two's-complement product does not depend on operand
  // signedness, so a same-width multiply yields the truncated signed result.
  generate
    for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_lane
      assign prod_o[lane_lsb(gi, TOTAL_WIDTH) +: TOTAL_WIDTH] =
        vec_i[lane_lsb(gi, TOTAL_WIDTH) +: TOTAL_WIDTH] * scalar_i;
    end
  endgenerate

endmodule

// File: rtl/scalar_mult_scheduler.sv
// Job-level controller streaming multi-chunk vectors through the scalar
// multiplier into a single full-throughput output register.
module scalar_mult_scheduler
  import xnor_pkg::*;
#(
  parameter int TOTAL_WIDTH = DEF_TOTAL_WIDTH,
  parameter int VECTOR_SIZE = DEF_VECTOR_SIZE,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               job_valid,
  output logic                               job_ready,
  input  logic [TOTAL_WIDTH-1:0]             job_scalar,
  input  logic [CNT_WIDTH-1:0]               job_chunks,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [TOTAL_WIDTH*VECTOR_SIZE-1:0] in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [TOTAL_WIDTH*VECTOR_SIZE-1:0] out_data,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);

  localparam int DW = TOTAL_WIDTH * VECTOR_SIZE;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [TOTAL_WIDTH-1:0] scalar_q, scalar_d;
  logic [CNT_WIDTH-1:0]   remaining_q, remaining_d;
  logic                   out_valid_q, out_valid_d;
  logic [DW-1:0]          out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   done_q, done_d;
  logic [DW-1:0]          prod;

  scalar_multiplier_v #(
    .TOTAL_WIDTH(TOTAL_WIDTH),
    .VECTOR_SIZE(VECTOR_SIZE)
  ) u_mult (
    .scalar_i(scalar_q),
    .vec_i   (in_data),
    .prod_o  (prod)
  );

  always_comb begin
    state_d     = state_q;
    scalar_d    = scalar_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    job_ready   = 1'b0;
    in_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          scalar_d    = job_scalar;
          remaining_d = job_chunks;
          if (job_chunks == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Accept whenever the output register is empty or draining this cycle.
        in_ready = !out_valid_q || out_ready;
        if (in_valid && in_ready) begin
          out_data_d  = prod;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == CNT_ONE);
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d = ST_DRAIN;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      scalar_q    <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      scalar_q    <= scalar_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scalar_mult_scheduler.sv
// Scenario bench for scalar_mult_scheduler: a negedge monitor keeps a
// scoreboard of expected output beats; each task checks its own scenario.
module tb_scalar_mult_scheduler;

  localparam int TW = 32;
  localparam int VS = 4;
  localparam int CW = 4;
  localparam int DW = TW * VS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [TW-1:0] job_scalar = '0;
  logic [CW-1:0] job_chunks = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  scalar_mult_scheduler #(
    .TOTAL_WIDTH(TW),
    .VECTOR_SIZE(VS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_scalar(job_scalar),
    .job_chunks(job_chunks),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [TW-1:0] m_scalar = '0;
  int            m_remaining = 0;
  int            acc_cnt = 0;
  int            beat_cnt = 0;
  int            done_cnt = 0;
  int            job_cnt = 0;

  function automatic logic [DW-1:0] model_prod(input logic [DW-1:0] d, input logic [TW-1:0] s);
    logic [DW-1:0] r;
    logic [TW-1:0] lane;
    r = '0;
    for (int i = 0; i < VS; i++) begin
      lane = d[i*TW +: TW];
      r[i*TW +: TW] = lane * s;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard: expectations pushed on input acceptance, popped on output consume.
  always @(negedge clk) begin : monitor
    beat_t b;
    if (rst_n) begin
      if (job_valid && job_ready) begin
        m_scalar    = job_scalar;
        m_remaining = int'(job_chunks);
        job_cnt++;
      end
      if (out_valid && out_ready) begin
        beat_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_beat: got data=%h last=%0b, required no beat", out_data, out_last);
        end else begin
          b = exp_q.pop_front();
          if (out_data !== b.data || out_last !== b.last) begin
            n_fail++;
            $display("FAIL out_beat: got data=%h last=%0b, required data=%h last=%0b",
                     out_data, out_last, b.data, b.last);
          end
        end
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        n_checks++;
        if (m_remaining <= 0) begin
          n_fail++;
          $display("FAIL accept_without_job: got in_ready=1 with %0d chunks left, required 0", m_remaining);
        end else begin
          b.data = model_prod(in_data, m_scalar);
          b.last = (m_remaining == 1);
          exp_q.push_back(b);
          m_remaining--;
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %0b required 0", out_last); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b required 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
    n_checks++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %0b required 1", job_ready); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
    rst_n = 1'b1;
    step();
    $display("test_reset: complete");
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    int dn0;
    d = {32'h7FFFFFFF, 32'd5, 32'hFFFFFFFE, 32'd1};
    e = {32'h7FFFFFFD, 32'd15, 32'hFFFFFFFA, 32'd3};
    dn0 = done_cnt;
    job_valid = 1'b1; job_scalar = 32'd3; job_chunks = 4'd1; out_ready = 1'b0;
    step();
    job_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0b required 1", busy); end
    n_checks++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL single_job_ready: got %0b required 0", job_ready); end
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0; in_data = '1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %0b required 1", out_valid); end
    n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL single_out_data: got %h required %h", out_data, e); end
    n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL single_out_last: got %0b required 1", out_last); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_in_ready_drain: got %0b required 0", in_ready); end
    step();
    n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL single_hold_data: got %h required %h", out_data, e); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_early_done: got %0b required 0", done); end
    out_ready = 1'b1;
    step();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %0b required 1", done); end
    n_checks++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL single_job_ready_done: got %0b required 1", job_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_out_valid_clear: got %0b required 0", out_valid); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %0b required 0", done); end
    n_checks++; if (done_cnt - dn0 !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d required 1", done_cnt - dn0); end
    $display("test_single: complete");
  endtask

  task automatic test_streaming();
    int b0;
    int dn0;
    job_valid = 1'b1; job_scalar = 32'hFFFFFFFF; job_chunks = 4'd4; out_ready = 1'b1;
    step();
    job_valid = 1'b0;
    b0 = beat_cnt; dn0 = done_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = rand_vec();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %0b required 1", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stream_in_ready_drain: got %0b required 0", in_ready); end
    n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL stream_last: got %0b required 1", out_last); end
    step();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stream_done: got %0b required 1", done); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stream_done_pulse: got %0b required 0", done); end
    n_checks++; if (beat_cnt - b0 !== 4) begin n_fail++; $display("FAIL stream_beats: got %0d required 4", beat_cnt - b0); end
    n_checks++; if (done_cnt - dn0 !== 1) begin n_fail++; $display("FAIL stream_done_count: got %0d required 1", done_cnt - dn0); end
    $display("test_streaming: complete");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d[3];
    logic [DW-1:0] e0;
    int a0, b0, dn0;
    for (int i = 0; i < 3; i++) d[i] = rand_vec();
    e0 = model_prod(d[0], 32'd7);
    job_valid = 1'b1; job_scalar = 32'd7; job_chunks = 4'd3; out_ready = 1'b0;
    step();
    job_valid = 1'b0;
    a0 = acc_cnt; b0 = beat_cnt; dn0 = done_cnt;
    in_valid = 1'b1; in_data = d[0];
    step();
    in_data = d[1];
    for (int t = 0; t < 5; t++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b required 0", t, in_ready); end
      n_checks++; if (out_valid !== 1'b1 || out_data !== e0 || out_last !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b last=%0b data=%h required v=1 last=0 data=%h",
                           t, out_valid, out_last, out_data, e0);
      end
      step();
    end
    out_ready = 1'b1;
    for (int t = 0; t < 20 && (beat_cnt - b0 < 3 || done_cnt == dn0); t++) begin
      if (acc_cnt - a0 >= 3) in_valid = 1'b0;
      else in_data = d[acc_cnt - a0];
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (acc_cnt - a0 !== 3) begin n_fail++; $display("FAIL bp_accepts: got %0d required 3", acc_cnt - a0); end
    n_checks++; if (beat_cnt - b0 !== 3) begin n_fail++; $display("FAIL bp_beats: got %0d required 3", beat_cnt - b0); end
    n_checks++; if (done_cnt - dn0 !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d required 1", done_cnt - dn0); end
    $display("test_backpressure: complete");
  endtask

  task automatic test_zero_length();
    int dn0, a0;
    dn0 = done_cnt; a0 = acc_cnt;
    job_valid = 1'b1; job_scalar = 32'd5; job_chunks = 4'd0; in_valid = 1'b1; in_data = rand_vec();
    step();
    job_valid = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %0b required 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %0b required 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_out_valid: got %0b required 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_in_ready: got %0b required 0", in_ready); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %0b required 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %0b required 0", busy); end
    in_valid = 1'b0;
    n_checks++; if (acc_cnt - a0 !== 0) begin n_fail++; $display("FAIL zero_idle_accepts: got %0d required 0", acc_cnt - a0); end
    n_checks++; if (done_cnt - dn0 !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d required 1", done_cnt - dn0); end
    $display("test_zero_length: complete");
  endtask

  task automatic test_reset_mid_job();
    int dn0, b0;
    job_valid = 1'b1; job_scalar = 32'd5; job_chunks = 4'd4; out_ready = 1'b1;
    step();
    job_valid = 1'b0; in_valid = 1'b1; in_data = rand_vec();
    step();
    in_data = rand_vec();
    step();
    dn0 = done_cnt;
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    m_remaining = 0;
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got v=%0b last=%0b data=%h required all 0", out_valid, out_last, out_data);
    end
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_done_busy: got done=%0b busy=%0b required 0 0", done, busy); end
    n_checks++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_job_ready: got %0b required 1", job_ready); end
    step(); step(); step();
    n_checks++; if (done_cnt !== dn0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses required 0", done_cnt - dn0); end
    b0 = beat_cnt;
    job_valid = 1'b1; job_scalar = 32'd11; job_chunks = 4'd1;
    step();
    job_valid = 1'b0; in_valid = 1'b1; in_data = rand_vec();
    step();
    in_valid = 1'b0;
    step();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL midrst_new_job_done: got %0b required 1", done); end
    n_checks++; if (beat_cnt - b0 !== 1) begin n_fail++; $display("FAIL midrst_new_job_beats: got %0d required 1", beat_cnt - b0); end
    step();
    $display("test_reset_mid_job: complete");
  endtask

  task automatic test_overflow();
    logic [TW-1:0] sc[2];
    logic [DW-1:0] din[2];
    logic [DW-1:0] ex[2];
    sc[0] = 32'h00010000;
    din[0] = {32'h0000FFFF, 32'd1, 32'h00010000, 32'h00010000};
    ex[0] = {32'hFFFF0000, 32'h00010000, 32'd0, 32'd0};
    sc[1] = 32'h80000000;
    din[1] = {32'd0, 32'd2, 32'd1, 32'hFFFFFFFF};
    ex[1] = {32'd0, 32'd0, 32'h80000000, 32'h80000000};
    for (int k = 0; k < 2; k++) begin
      job_valid = 1'b1; job_scalar = sc[k]; job_chunks = 4'd1; out_ready = 1'b1;
      step();
      job_valid = 1'b0; in_valid = 1'b1; in_data = din[k];
      step();
      in_valid = 1'b0;
      n_checks++; if (out_data !== ex[k]) begin n_fail++; $display("FAIL overflow[%0d]: got %h required %h", k, out_data, ex[k]); end
      step();
      step();
    end
    $display("test_overflow: complete");
  endtask

  task automatic test_max_count();
    int b0, dn0, t;
    b0 = beat_cnt; dn0 = done_cnt;
    job_valid = 1'b1; job_scalar = $urandom(); job_chunks = 4'hF;
    step();
    job_valid = 1'b0;
    for (t = 0; t < 400 && done_cnt == dn0; t++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = rand_vec();
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (t >= 400) begin n_fail++; $display("FAIL maxcnt_timeout: got no done in %0d cycles required done", t); end
    n_checks++; if (beat_cnt - b0 !== 15) begin n_fail++; $display("FAIL maxcnt_beats: got %0d required 15", beat_cnt - b0); end
    n_checks++; if (done_cnt - dn0 !== 1) begin n_fail++; $display("FAIL maxcnt_done_count: got %0d required 1", done_cnt - dn0); end
    step();
    $display("test_max_count: complete");
  endtask

  task automatic test_back_to_back();
    int b0, dn0, j0, t;
    b0 = beat_cnt; dn0 = done_cnt; j0 = job_cnt;
    job_valid = 1'b1; job_scalar = 32'd2; job_chunks = 4'd2; out_ready = 1'b1;
    step();
    job_scalar = 32'd9; job_chunks = 4'd1;
    in_valid = 1'b1;
    for (t = 0; t < 40 && done_cnt - dn0 < 2; t++) begin
      if (job_cnt - j0 >= 2) job_valid = 1'b0;
      in_data = rand_vec();
      if (busy === 1'b1) begin
        n_checks++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_job_ready_busy[%0d]: got %0b required 0", t, job_ready); end
      end
      step();
    end
    job_valid = 1'b0; in_valid = 1'b0;
    n_checks++; if (t >= 40) begin n_fail++; $display("FAIL b2b_timeout: got %0d done pulses required 2", done_cnt - dn0); end
    n_checks++; if (job_cnt - j0 !== 2) begin n_fail++; $display("FAIL b2b_jobs: got %0d required 2", job_cnt - j0); end
    n_checks++; if (beat_cnt - b0 !== 3) begin n_fail++; $display("FAIL b2b_beats: got %0d required 3", beat_cnt - b0); end
    n_checks++; if (done_cnt - dn0 !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d required 2", done_cnt - dn0); end
    step();
    $display("test_back_to_back: complete");
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_zero_length();
    test_reset_mid_job();
    test_overflow();
    test_max_count();
    test_back_to_back();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending beats required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
